// File: rtl/plate_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : plate_frame_tx
// Description : Buffers up to two pixel frames and streams each one as
//               FRAME_W/WORD_W data beats followed by an XOR checksum beat.
// Revision    : 1.0 - initial release
// ============================================================================
module plate_frame_tx #(
    parameter int FRAME_W = 1024,
    parameter int WORD_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic [2:0]         frame_board,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [WORD_W-1:0]  word_data,
    output logic               word_first,
    output logic               word_last,
    output logic [2:0]         word_board,
    output logic [7:0]         frame_cnt,
    output logic               err_board
);
    localparam int                  c_NUM_BEATS = FRAME_W / WORD_W;
    localparam int                  c_BEAT_W    = (c_NUM_BEATS > 1) ? $clog2(c_NUM_BEATS) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_NUM_BEATS - 1);
    localparam logic [2:0]          c_MAX_BOARD = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_CSUM = 2'd2
    } state_t;

    state_t              r_state;
    logic [FRAME_W-1:0]  r_fifo_data  [2];
    logic [2:0]          r_fifo_board [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;
    logic [c_BEAT_W-1:0] r_beat;

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_start_avail;
    logic                w_next_avail;
    logic [FRAME_W-1:0]  w_head_data;
    logic [FRAME_W-1:0]  w_start_data;
    logic [FRAME_W-1:0]  w_next_data;
    logic [2:0]          w_start_board;
    logic [2:0]          w_next_board;
    logic [WORD_W-1:0]   w_head_words [c_NUM_BEATS];
    logic [WORD_W-1:0]   w_csum;
    logic [c_BEAT_W-1:0] w_beat_nxt;

    // The frame on the stream keeps its FIFO slot until its checksum beat is taken.
    assign frame_ready = ~reset & (r_count != 2'd2);
    assign w_accept    = frame_valid & frame_ready;
    assign w_push      = w_accept & (frame_board <= c_MAX_BOARD);
    assign w_pop       = (r_state == S_CSUM) & word_ready;
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_beat_nxt  = r_beat + c_BEAT_W'(1);

    // Starting from idle, an empty FIFO forwards the incoming frame directly.
    assign w_start_avail = (r_count != 2'd0) | w_push;
    assign w_start_data  = (r_count != 2'd0) ? w_head_data : frame_data;
    assign w_start_board = (r_count != 2'd0) ? r_fifo_board[r_rd_ptr] : frame_board;

    // Successor of the frame being retired: the other slot, or a frame arriving now.
    assign w_next_avail = (r_count == 2'd2) | w_push;
    assign w_next_data  = (r_count == 2'd2) ? r_fifo_data[~r_rd_ptr] : frame_data;
    assign w_next_board = (r_count == 2'd2) ? r_fifo_board[~r_rd_ptr] : frame_board;

    generate
        for (genvar gi = 0; gi < c_NUM_BEATS; gi++) begin : g_words
            assign w_head_words[gi] = w_head_data[gi*WORD_W +: WORD_W];
        end
    endgenerate

    always_comb begin
        w_csum = '0;
        for (int i = 0; i < c_NUM_BEATS; i++) begin
            w_csum = w_csum ^ w_head_words[i];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr]  <= frame_data;
            r_fifo_board[r_wr_ptr] <= frame_board;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_beat     <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_first <= 1'b0;
            word_last  <= 1'b0;
            word_board <= 3'd0;
            frame_cnt  <= 8'd0;
            err_board  <= 1'b0;
        end else begin
            err_board <= w_accept & (frame_board > c_MAX_BOARD);
            r_count   <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;

            case (r_state)
                S_IDLE: begin
                    if (w_start_avail) begin
                        r_state    <= S_SEND;
                        r_beat     <= '0;
                        word_valid <= 1'b1;
                        word_data  <= w_start_data[WORD_W-1:0];
                        word_first <= 1'b1;
                        word_last  <= 1'b0;
                        word_board <= w_start_board;
                    end
                end
                S_SEND: begin
                    if (word_ready) begin
                        word_first <= 1'b0;
                        if (r_beat == c_LAST_BEAT) begin
                            r_state   <= S_CSUM;
                            word_data <= w_csum;
                            word_last <= 1'b1;
                        end else begin
                            r_beat    <= w_beat_nxt;
                            word_data <= w_head_words[w_beat_nxt];
                        end
                    end
                end
                S_CSUM: begin
                    if (word_ready) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        word_last <= 1'b0;
                        if (w_next_avail) begin
                            r_state    <= S_SEND;
                            r_beat     <= '0;
                            word_data  <= w_next_data[WORD_W-1:0];
                            word_first <= 1'b1;
                            word_board <= w_next_board;
                        end else begin
                            r_state    <= S_IDLE;
                            word_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    word_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_plate_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_plate_frame_tx
// Description : Directed self-checking bench for plate_frame_tx with a beat
//               scoreboard and stall-stability monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plate_frame_tx;
    localparam int FW = 1024;
    localparam int WW = 32;
    localparam int NB = FW / WW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_valid = 1'b0;
    logic          frame_ready;
    logic [FW-1:0] frame_data = '0;
    logic [2:0]    frame_board = 3'd0;
    logic          word_valid;
    logic          word_ready;
    logic [WW-1:0] word_data;
    logic          word_first;
    logic          word_last;
    logic [2:0]    word_board;
    logic [7:0]    frame_cnt;
    logic          err_board;

    plate_frame_tx #(.FRAME_W(FW), .WORD_W(WW)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_board (frame_board),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .word_first  (word_first),
        .word_last   (word_last),
        .word_board  (word_board),
        .frame_cnt   (frame_cnt),
        .err_board   (err_board)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] d;
        logic          f;
        logic          l;
        logic [2:0]    b;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    ready_mode = 1;
    int    gaps = 0;
    bit    gap_watch = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // word_ready: 0 = stalled, 1 = always ready, 2 = repeating 1,0,0,1
    initial begin
        int ph;
        ph = 0;
        word_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       word_ready = 1'b0;
                1:       word_ready = 1'b1;
                default: word_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            endcase
            ph++;
        end
    end

    // Scoreboard for completed beats plus hold-stable check while stalled.
    logic          have_stall = 1'b0;
    logic [WW-1:0] s_data;
    logic [4:0]    s_flags;
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            have_stall = 1'b0;
        end else begin
            if (have_stall) begin
                check("stall_valid", word_valid, 1);
                check("stall_data", word_data, s_data);
                check("stall_flags", {word_first, word_last, word_board}, s_flags);
            end
            if (gap_watch && !word_valid) gaps++;
            if (word_valid && word_ready) begin
                check("beat_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("beat_data", word_data, e.d);
                    check("beat_flags", {word_first, word_last, word_board}, {e.f, e.l, e.b});
                end
            end
            have_stall = word_valid && !word_ready;
            s_data     = word_data;
            s_flags    = {word_first, word_last, word_board};
        end
    end

    function automatic logic [FW-1:0] mk_frame(input bit ramp);
        logic [FW-1:0] f;
        for (int k = 0; k < NB; k++) f[k*WW +: WW] = ramp ? WW'(k) : $urandom;
        return f;
    endfunction

    // Offers a frame until accepted; returns at accept edge + 1.
    task automatic send_frame(input logic [FW-1:0] d, input logic [2:0] b, output int waits);
        logic [WW-1:0] x;
        bit            ok;
        waits = 0;
        ok    = 1'b0;
        x     = '0;
        frame_data  = d;
        frame_board = b;
        frame_valid = 1'b1;
        while (!ok && waits < 500) begin
            @(negedge clk);
            if (frame_ready) ok = 1'b1;
            else waits++;
        end
        check("accept_timeout", ok, 1);
        if (ok && b <= 3'd4) begin
            for (int k = 0; k < NB; k++) begin
                q.push_back('{d: d[k*WW +: WW], f: (k == 0), l: 1'b0, b: b});
                x = x ^ d[k*WW +: WW];
            end
            q.push_back('{d: x, f: 1'b0, l: 1'b1, b: b});
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        frame_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || word_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 3000, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            w;
        logic [FW-1:0] fa;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", word_valid, 0);
        check("rst_ready", frame_ready, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_err", err_board, 0);
        check("rst_outs", {word_data, word_first, word_last, word_board}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", frame_ready, 1);

        // Single ramp frame, then a frame accepted on the checksum edge
        @(posedge clk);
        #1;
        fa = mk_frame(1'b1);
        send_frame(fa, 3'd2, w);
        @(negedge clk);
        check("lat1_valid", word_valid, 1);
        check("lat1_first", word_first, 1);
        check("lat1_data", word_data, 0);
        repeat (32) @(posedge clk);
        #1;
        send_frame(mk_frame(1'b0), 3'd3, w);
        check("simul_waits", w, 0);
        @(negedge clk);
        check("b2b_valid", word_valid, 1);
        check("b2b_first", word_first, 1);
        check("b2b_board", word_board, 3);
        check("simul_occupancy", frame_ready, 1);
        check("cnt_single", frame_cnt, 1);
        wait_idle();
        check("cnt_two", frame_cnt, 2);

        // Backpressure 1,0,0,1
        ready_mode = 2;
        @(posedge clk);
        #1;
        send_frame(mk_frame(1'b0), 3'd1, w);
        wait_idle();
        check("cnt_bp", frame_cnt, 3);

        // Full FIFO with downstream stalled
        ready_mode = 0;
        @(posedge clk);
        #1;
        send_frame(mk_frame(1'b0), 3'd0, w);
        send_frame(mk_frame(1'b0), 3'd4, w);
        @(negedge clk);
        check("full_ready", frame_ready, 0);
        check("full_hold_first", word_first, 1);
        ready_mode = 1;
        send_frame(mk_frame(1'b0), 3'd2, w);
        check("full_wait", w, 33);
        wait_idle();
        check("cnt_full", frame_cnt, 6);

        // Illegal board index
        @(posedge clk);
        #1;
        send_frame(mk_frame(1'b0), 3'd5, w);
        @(negedge clk);
        check("err_pulse", err_board, 1);
        check("err_no_valid", word_valid, 0);
        @(negedge clk);
        check("err_one_cycle", err_board, 0);
        repeat (3) @(negedge clk);
        check("err_still_idle", word_valid, 0);
        check("err_cnt", frame_cnt, 6);

        // Reset while beat 10 is on the stream
        @(posedge clk);
        #1;
        fa = mk_frame(1'b0);
        send_frame(fa, 3'd1, w);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        q.delete();
        @(negedge clk);
        check("beat10_data", word_data, fa[10*WW +: WW]);
        @(negedge clk);
        check("midrst_valid", word_valid, 0);
        check("midrst_cnt", frame_cnt, 0);
        check("midrst_ready", frame_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", frame_ready, 1);
        check("midrst_idle", word_valid, 0);

        // 256 back-to-back frames wrap the counter
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            send_frame(mk_frame(1'b0), 3'(i % 5), w);
            if (i == 0) gap_watch = 1'b1;
        end
        gap_watch = 1'b0;
        wait_idle();
        check("wrap_cnt", frame_cnt, 0);
        check("gapless", gaps, 0);
        check("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
